// File: rtl/mems_telemetry_sequencer.sv
// Captures SPI readback words on a synchronised rx_done fall and replays them as paced UART words.
// Latency: first tx_start 2 sclk after the capture event (IDLE, enable high); words spaced >= GAP_CYCLES.
// Backpressure: tx_busy stalls HOLD indefinitely with no word loss; a capture while one is pending sets overrun.
module mems_telemetry_sequencer #(
   parameter int DATA_W        = 16,
   parameter int NUM_CH        = 2,
   parameter int GAP_CYCLES    = 6000,
   parameter int PERIOD_CYCLES = 1_000_000_000,
   parameter int REPEAT        = 0
) (
   input  logic                     sclk,
   input  logic                     rst_n,
   input  logic                     rx_done,
   input  logic [NUM_CH*DATA_W-1:0] rx_data,
   input  logic                     enable,
   input  logic                     tx_busy,
   input  logic                     clr_overrun,
   output logic                     tx_start,
   output logic [DATA_W-1:0]        tx_data,
   output logic                     frame_done,
   output logic                     overrun
);

   localparam int CNT_MAX = (GAP_CYCLES > PERIOD_CYCLES) ? GAP_CYCLES : PERIOD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [CNT_W-1:0] CNT_SAT    = '1;
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PERIOD_END = CNT_W'(PERIOD_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      HOLD   = 2'd2,
      PERIOD = 2'd3
   } state_t;

   state_t                     state_q;
   state_t                     state_d;

   logic                       s1;
   logic                       s2;
   logic                       cap_evt;

   logic [NUM_CH*DATA_W-1:0]   shadow_q;
   logic [NUM_CH*DATA_W-1:0]   snapshot_q;
   logic                       pending_q;
   logic                       overrun_q;
   logic                       frame_done_q;
   logic [IDX_W-1:0]           idx_q;
   logic [CNT_W-1:0]           counter_q;

   // FSM-derived strobes driving the datapath
   logic                       start_frame;
   logic                       next_word;
   logic                       end_frame;
   logic                       period_done;
   logic                       rearm;
   logic                       hold_ok;

   // Capture event fires on the synchronised falling edge of rx_done
   assign cap_evt = ~s1 & s2;

   // Two-flop synchroniser for the asynchronous rx_done level
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= rx_done;
         s2 <= s1;
      end
   end

   // FSM state register
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_frame) begin
               state_d = SEND;
            end
         end
         SEND: begin
            state_d = HOLD;
         end
         HOLD: begin
            if (end_frame) begin
               state_d = PERIOD;
            end else if (next_word) begin
               state_d = SEND;
            end
         end
         PERIOD: begin
            if (period_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs: UART strobe plus datapath control strobes
   always_comb begin
      tx_start    = 1'b0;
      start_frame = 1'b0;
      hold_ok     = 1'b0;
      next_word   = 1'b0;
      end_frame   = 1'b0;
      period_done = 1'b0;
      rearm       = 1'b0;
      case (state_q)
         IDLE: begin
            start_frame = pending_q & enable;
         end
         SEND: begin
            tx_start = 1'b1;
         end
         HOLD: begin
            // counter holds cycles since this word's tx_start, so >= GAP-1 here
            // places the next tx_start exactly GAP_CYCLES after the previous one
            hold_ok   = (counter_q >= GAP_LAST) && !tx_busy;
            next_word = hold_ok && (idx_q != IDX_LAST);
            end_frame = hold_ok && (idx_q == IDX_LAST);
         end
         PERIOD: begin
            // first PERIOD cycle is the frame_done cycle; PERIOD_CYCLES idle cycles follow
            period_done = (counter_q >= PERIOD_END);
            rearm       = period_done && (REPEAT != 0);
         end
         default: begin
            tx_start = 1'b0;
         end
      endcase
   end

   // Shadow buffer takes every capture, overwriting any unsent one
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else if (cap_evt) begin
         shadow_q <= rx_data;
      end
   end

   // Pending flag: capture wins over consumption so a same-cycle capture is not lost
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= 1'b0;
      end else if (cap_evt) begin
         pending_q <= 1'b1;
      end else if (start_frame) begin
         pending_q <= 1'b0;
      end else if (rearm) begin
         pending_q <= 1'b1;
      end
   end

   // Sticky overrun: a capture onto an unconsumed pending capture; setting beats clearing
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (cap_evt && pending_q && !start_frame) begin
         overrun_q <= 1'b1;
      end else if (clr_overrun) begin
         overrun_q <= 1'b0;
      end
   end

   // Snapshot is frozen for the whole frame; only a frame start reloads it
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         snapshot_q <= '0;
      end else if (start_frame) begin
         snapshot_q <= shadow_q;
      end
   end

   // Channel index walks 0..NUM_CH-1 across the frame
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else if (start_frame) begin
         idx_q <= '0;
      end else if (next_word) begin
         idx_q <= idx_q + IDX_W'(1);
      end
   end

   // Shared gap/period counter; cleared on entry to SEND and PERIOD, saturates so a long stall cannot wrap
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         counter_q <= '0;
      end else if (start_frame || next_word || end_frame) begin
         counter_q <= '0;
      end else if (counter_q != CNT_SAT) begin
         counter_q <= counter_q + CNT_W'(1);
      end
   end

   // frame_done is registered so it lands on the first PERIOD cycle
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= end_frame;
      end
   end

   // Current word stays on tx_data from its tx_start until the next one
   always_comb begin
      tx_data = snapshot_q[32'(idx_q) * DATA_W +: DATA_W];
   end

   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_mems_telemetry_sequencer.sv
// Directed bench for mems_telemetry_sequencer: two instances (REPEAT=0 and REPEAT=1).
// Monitors log tx_start/frame_done cycles; scenarios compare against hand-computed timings.
// Inputs driven 1ns after the rising edge; outputs sampled there or on the falling edge.
module tb_mems_telemetry_sequencer;

   logic        sclk = 1'b0;
   logic        rst0_n;
   logic        rst1_n;
   logic        rx_done;
   logic [31:0] rx_data;
   logic        enable;
   logic        tx_busy;
   logic        clr_overrun;

   logic        tx_start0, frame_done0, overrun0;
   logic [15:0] tx_data0;
   logic        tx_start1, frame_done1, overrun1;
   logic [15:0] tx_data1;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   int          tx0_cyc[$];
   int          tx0_val[$];
   int          fd0_cyc[$];
   int          tx1_cyc[$];
   int          tx1_val[$];

   always #5 sclk = ~sclk;

   always @(posedge sclk) cyc <= cyc + 1;

   // Event logs, sampled on the falling edge
   always @(negedge sclk) begin
      if (tx_start0) begin
         tx0_cyc.push_back(cyc);
         tx0_val.push_back(int'(tx_data0));
      end
      if (frame_done0) fd0_cyc.push_back(cyc);
      if (tx_start1) begin
         tx1_cyc.push_back(cyc);
         tx1_val.push_back(int'(tx_data1));
      end
   end

   mems_telemetry_sequencer #(
      .DATA_W(16), .NUM_CH(2), .GAP_CYCLES(8), .PERIOD_CYCLES(20), .REPEAT(0)
   ) dut0 (
      .sclk(sclk), .rst_n(rst0_n), .rx_done(rx_done), .rx_data(rx_data),
      .enable(enable), .tx_busy(tx_busy), .clr_overrun(clr_overrun),
      .tx_start(tx_start0), .tx_data(tx_data0), .frame_done(frame_done0), .overrun(overrun0)
   );

   mems_telemetry_sequencer #(
      .DATA_W(16), .NUM_CH(2), .GAP_CYCLES(8), .PERIOD_CYCLES(20), .REPEAT(1)
   ) dut1 (
      .sclk(sclk), .rst_n(rst1_n), .rx_done(rx_done), .rx_data(rx_data),
      .enable(enable), .tx_busy(tx_busy), .clr_overrun(clr_overrun),
      .tx_start(tx_start1), .tx_data(tx_data1), .frame_done(frame_done1), .overrun(overrun1)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge sclk);
         #1;
      end
   endtask

   task automatic step_to(input int target);
      while (cyc < target) step(1);
   endtask

   // Pulse rx_done for 3 cycles; fall = cycle count when rx_done is lowered
   task automatic capture(input logic [31:0] d, output int fall);
      rx_data = d;
      rx_done = 1'b1;
      step(3);
      rx_done = 1'b0;
      fall = cyc;
   endtask

   task automatic clear_logs;
      tx0_cyc.delete();
      tx0_val.delete();
      fd0_cyc.delete();
      tx1_cyc.delete();
      tx1_val.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int f, f1, f2, busy_fall, en_at;

      rst0_n      = 1'b0;
      rst1_n      = 1'b0;
      rx_done     = 1'b0;
      rx_data     = '0;
      enable      = 1'b1;
      tx_busy     = 1'b0;
      clr_overrun = 1'b0;
      step(3);

      // Reset state
      chk("rst_tx_start",   int'(tx_start0),   0);
      chk("rst_tx_data",    int'(tx_data0),    0);
      chk("rst_frame_done", int'(frame_done0), 0);
      chk("rst_overrun",    int'(overrun0),    0);
      chk("rst1_tx_start",  int'(tx_start1),   0);
      rst0_n = 1'b1;
      step(2);

      // Scenario 1: basic frame, gap 8, frame_done 8 later, then quiet period
      clear_logs();
      capture(32'hBEEF_1234, f);
      step_to(f + 60);
      chk("s1_tx_count",   tx0_cyc.size(), 2);
      chk("s1_latency",    tx0_cyc[0] - f, 3);
      chk("s1_word0",      tx0_val[0], 32'h1234);
      chk("s1_gap",        tx0_cyc[1] - tx0_cyc[0], 8);
      chk("s1_word1",      tx0_val[1], 32'hBEEF);
      chk("s1_fd_count",   fd0_cyc.size(), 1);
      chk("s1_fd_delay",   fd0_cyc[0] - tx0_cyc[1], 8);
      chk("s1_data_hold",  int'(tx_data0), 32'hBEEF);

      // Scenario 2: tx_busy stall for 50 cycles after first tx_start
      clear_logs();
      capture(32'h0B0B_0A0A, f);
      step_to(f + 3);
      tx_busy = 1'b1;
      step(50);
      chk("s2_stalled", tx0_cyc.size(), 1);
      tx_busy = 1'b0;
      busy_fall = cyc;
      step_to(f + 90);
      chk("s2_tx_count",  tx0_cyc.size(), 2);
      chk("s2_word0",     tx0_val[0], 32'h0A0A);
      chk("s2_release",   tx0_cyc[1] - busy_fall, 1);
      chk("s2_word1",     tx0_val[1], 32'h0B0B);
      chk("s2_fd_delay",  fd0_cyc[0] - tx0_cyc[1], 8);

      // Scenario 3: capture during HOLD, another during PERIOD -> overrun, newest data wins
      clear_logs();
      chk("s3_ovr_start", int'(overrun0), 0);
      capture(32'h00B2_00B1, f1);
      step(4);
      capture(32'h0002_0001, f2);
      step(10);
      chk("s3_no_ovr_mid", int'(overrun0), 0);
      capture(32'h0004_0003, f);
      step(3);
      chk("s3_overrun", int'(overrun0), 1);
      step_to(f1 + 70);
      chk("s3_tx_count",  tx0_cyc.size(), 4);
      chk("s3_f1_word0",  tx0_val[0], 32'h00B1);
      chk("s3_f1_word1",  tx0_val[1], 32'h00B2);
      chk("s3_f2_start",  tx0_cyc[2] - f1, 41);
      chk("s3_f2_word0",  tx0_val[2], 32'h0003);
      chk("s3_f2_word1",  tx0_val[3], 32'h0004);
      chk("s3_ovr_sticky", int'(overrun0), 1);
      clr_overrun = 1'b1;
      step(1);
      clr_overrun = 1'b0;
      chk("s3_ovr_clr", int'(overrun0), 0);
      step_to(f1 + 90);

      // Scenario 5: captures with enable low; set-vs-clear priority; late enable
      clear_logs();
      enable = 1'b0;
      capture(32'h0D02_0D01, f);
      step(3);
      chk("s5_ovr_first", int'(overrun0), 0);
      capture(32'h0E02_0E01, f2);
      step(1);
      clr_overrun = 1'b1;
      step(1);
      clr_overrun = 1'b0;
      chk("s5_ovr_priority", int'(overrun0), 1);
      clr_overrun = 1'b1;
      step(1);
      clr_overrun = 1'b0;
      chk("s5_ovr_cleared", int'(overrun0), 0);
      step_to(f2 + 100);
      chk("s5_no_tx", tx0_cyc.size(), 0);
      enable = 1'b1;
      en_at = cyc;
      step(30);
      chk("s5_tx_count", tx0_cyc.size(), 2);
      chk("s5_start",    tx0_cyc[0] - en_at, 1);
      chk("s5_word0",    tx0_val[0], 32'h0E01);
      chk("s5_word1",    tx0_val[1], 32'h0E02);
      step(30);

      // Scenario 4: REPEAT instance, periodic frames, mid-frame reset
      chk("s4_rst_tx_data", int'(tx_data1), 0);
      rst1_n = 1'b1;
      step(2);
      clear_logs();
      capture(32'hAAAA_5555, f);
      step_to(f + 85);
      chk("s4_tx_count",  tx1_cyc.size(), 5);
      chk("s4_latency",   tx1_cyc[0] - f, 3);
      chk("s4_period_a",  tx1_cyc[2] - tx1_cyc[0], 38);
      chk("s4_period_b",  tx1_cyc[4] - tx1_cyc[2], 38);
      chk("s4_rep_word0", tx1_val[2], 32'h5555);
      chk("s4_rep_word1", tx1_val[3], 32'hAAAA);
      rst1_n = 1'b0;
      #1;
      chk("s4_rst_tx_start",   int'(tx_start1),   0);
      chk("s4_rst_tx_data2",   int'(tx_data1),    0);
      chk("s4_rst_frame_done", int'(frame_done1), 0);
      chk("s4_rst_overrun",    int'(overrun1),    0);
      step(2);
      rst1_n = 1'b1;
      clear_logs();
      step(100);
      chk("s4_no_frame", tx1_cyc.size(), 0);
      capture(32'h00C2_00C1, f);
      step(20);
      chk("s4_new_count", tx1_cyc.size(), 2);
      chk("s4_new_word0", tx1_val[0], 32'h00C1);
      chk("s4_new_word1", tx1_val[1], 32'h00C2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mems_telemetry_sequencer.md
MEMS_TELEMETRY_SEQUENCER -- requirements
Module: mems_telemetry_sequencer

Interface
REQ-001 Parameter DATA_W, default 16: width of one telemetry word and of tx_data.
REQ-002 Parameter NUM_CH, default 2, range 1..8: number of words captured per SPI readback and sent per frame.
REQ-003 Parameter GAP_CYCLES, default 6000, minimum 1: minimum sclk cycles between successive tx_start pulses within a frame.
REQ-004 Parameter PERIOD_CYCLES, default 1_000_000_000, minimum 1: idle sclk cycles after a frame's last word.
REQ-005 Parameter REPEAT, default 0: 1 = resend the last snapshot every period without a new capture; 0 = send only after a new capture.
REQ-006 Counter width is ceil(log2(max(GAP_CYCLES, PERIOD_CYCLES)+1)) bits.
REQ-007 sclk  in  1  system clock, 50 MHz.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 rx_done  in  1  SPI readback done level, asynchronous to the sequencer's sampling domain.
REQ-010 rx_data  in  NUM_CH*DATA_W  readback words, channel k at bits [k*DATA_W +: DATA_W], stable while rx_done is high and for 3 cycles after it falls.
REQ-011 enable  in  1  permits starting a new frame.
REQ-012 tx_busy  in  1  UART transmitter busy.
REQ-013 clr_overrun  in  1  synchronous clear of overrun.
REQ-014 tx_start  out  1  one-cycle UART start pulse.
REQ-015 tx_data  out  DATA_W  word for UART, valid from the tx_start cycle until the next tx_start.
REQ-016 frame_done  out  1  one-cycle pulse after a frame's last word completes.
REQ-017 overrun  out  1  sticky: a capture arrived while a previous capture was still pending.

Function
REQ-018 rx_done SHALL pass through a 2-flop synchroniser (s1, s2); a capture event is s1==0 && s2==1.
REQ-019 On a capture event, all NUM_CH words of rx_data SHALL be loaded into a shadow buffer and pending set to 1.
REQ-020 If pending is already 1 at a capture event, the shadow SHALL be overwritten and overrun set to 1.
REQ-021 clr_overrun SHALL clear overrun; a simultaneous overrun-setting event takes priority, leaving overrun at 1.
REQ-022 FSM states SHALL be IDLE, SEND, HOLD, PERIOD.
REQ-023 IDLE: if pending && enable, copy shadow to snapshot, clear pending, idx=0, go to SEND; a capture event in the same cycle sets pending again and does not set overrun.
REQ-024 SEND: tx_start=1 for exactly one cycle; tx_data=snapshot[idx]; counter cleared; go to HOLD.
REQ-025 HOLD: counter increments each cycle; exit when counter >= GAP_CYCLES-1 and tx_busy==0.
REQ-026 HOLD exit: if idx==NUM_CH-1, pulse frame_done and go to PERIOD; otherwise idx+1 and go to SEND.
REQ-027 PERIOD: count PERIOD_CYCLES cycles, then go to IDLE; if REPEAT==1, set pending at exit without changing the shadow.
REQ-028 tx_busy held high SHALL stall HOLD indefinitely; no words SHALL be dropped.
REQ-029 enable deasserted mid-frame SHALL NOT abort; the frame and PERIOD complete and the FSM then waits in IDLE.
REQ-030 Channels SHALL be sent in order 0..NUM_CH-1; the snapshot SHALL stay unchanged during a frame.
REQ-031 Latency: tx_start for channel 0 SHALL occur 2 cycles after the capture event when the FSM is in IDLE with enable high.

Reset
REQ-032 While rst_n is low, all of the following SHALL be 0: tx_start, tx_data, frame_done, overrun, pending, idx, counter, s1, s2, shadow, snapshot; state SHALL be IDLE.
REQ-033 Reset asserted mid-frame SHALL abort immediately; the first frame after release requires a new capture event, even when REPEAT==1.

Verification
Bench parameters for all scenarios: DATA_W=16, NUM_CH=2, GAP_CYCLES=8, PERIOD_CYCLES=20.
REQ-034 Scenario 1: rx_data={16'hBEEF,16'h1234}, rx_done high then low, tx_busy=0 -> tx_start with tx_data=16'h1234, 8 cycles later tx_start with tx_data=16'hBEEF, frame_done pulse 8 cycles later, no tx_start for the next 20 cycles.
REQ-035 Scenario 2: tx_busy held high for 50 cycles after the first tx_start -> second tx_start occurs 1 cycle after tx_busy falls; no word lost.
REQ-036 Scenario 3: second capture {16'h0002,16'h0001} during HOLD, then third capture {16'h0004,16'h0003} before PERIOD ends -> overrun=1; next frame sends 16'h0003 then 16'h0004; clr_overrun returns overrun to 0.
REQ-037 Scenario 4: REPEAT=1, one capture {16'hAAAA,16'h5555} -> identical frames repeat every 2*8+20+2 cycles; all outputs 0 after rst_n pulses low mid-frame, and no frame until a new capture.
REQ-038 Scenario 5: enable=0 during a capture -> no tx_start; enable raised 100 cycles later -> frame starts within 2 cycles with the captured data.
